systolic_gemm_stream: RTL

//  Output-stationary ROWS x COLS fixed-point systolic GEMM engine: C = A(ROWSxK) * B(KxCOLS), K set per job.

---
 rtl/systolic_gemm_stream_if.sv | 41 ++++
 rtl/systolic_gemm_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_gemm_stream_if.sv
// Streaming port bundle for systolic_gemm_stream: job control, A/B operand beats and the C result stream.
// The slave modport is the engine side; the master modport is the producer/consumer side.
interface systolic_gemm_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 64
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                       start;
  logic [KW-1:0]              k_len;
  logic                       accum_en;
  logic [ROWS*DATA_WIDTH-1:0] a_vec;
  logic                       a_valid;
  logic                       a_ready;
  logic [COLS*DATA_WIDTH-1:0] b_vec;
  logic                       b_valid;
  logic                       b_ready;
  logic [DATA_WIDTH-1:0]      c_data;
  logic [RW-1:0]              c_row;
  logic [CW-1:0]              c_col;
  logic                       c_valid;
  logic                       c_ready;
  logic                       busy;
  logic                       done;

  modport slave (
    input  start, k_len, accum_en,
    input  a_vec, a_valid, b_vec, b_valid, c_ready,
    output a_ready, b_ready, c_data, c_row, c_col, c_valid, busy, done
  );

  modport master (
    output start, k_len, accum_en,
    output a_vec, a_valid, b_vec, b_valid, c_ready,
    input  a_ready, b_ready, c_data, c_row, c_col, c_valid, busy, done
  );
endinterface

// File: rtl/systolic_gemm_stream.sv
// Output-stationary ROWS x COLS fixed-point systolic GEMM; operands stream in one k-slice per beat,
// results stream out row-major with round-half-up and saturation. accum_en keeps partial sums across jobs.
module systolic_gemm_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 64,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input logic                   clk,
  input logic                   rst_n,
  systolic_gemm_stream_if.slave bus
);
  localparam int DW        = DATA_WIDTH;
  localparam int PW        = 2*DATA_WIDTH;
  localparam int AW        = ACC_WIDTH;
  localparam int AW1       = ACC_WIDTH + 1;
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  localparam logic signed [AW1-1:0] RND_BIAS = AW1'(1) << (FRAC_WIDTH - 1);
  localparam logic signed [AW1-1:0] SAT_MAX  = AW1'((2**(DW-1)) - 1);
  localparam logic signed [AW1-1:0] SAT_MIN  = -SAT_MAX - AW1'(1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_OUTPUT} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k_len;
  logic [KW-1:0]    r_beat_cnt;
  logic [DCW-1:0]   r_drain_cnt;
  logic             r_c_valid;
  logic [DW-1:0]    r_c_data;
  logic [RW-1:0]    r_c_row;
  logic [CW-1:0]    r_c_col;
  logic             r_busy;
  logic             r_done;

  logic             w_beat;
  logic             w_shift;
  logic             w_clear;
  logic [KW-1:0]    w_k_clamp;
  logic [RW-1:0]    w_nrow;
  logic [CW-1:0]    w_ncol;
  logic             w_last;

  logic signed [DW-1:0] w_a_edge [ROWS];
  logic signed [DW-1:0] w_b_edge [COLS];
  logic signed [DW-1:0] w_a_pe   [ROWS][COLS];
  logic signed [DW-1:0] w_b_pe   [ROWS][COLS];
  logic signed [AW-1:0] w_acc    [ROWS][COLS];

  logic signed [AW-1:0]  w_sel;
  logic signed [AW1-1:0] w_rnd;
  logic signed [AW1-1:0] w_shr;
  logic [DW-1:0]         w_res;

  assign w_beat    = (r_state == S_FEED) && bus.a_valid && bus.b_valid;
  assign w_shift   = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_clear   = (r_state == S_IDLE) && bus.start && !bus.accum_en;
  assign w_k_clamp = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;

  assign bus.a_ready = w_beat;
  assign bus.b_ready = w_beat;
  assign bus.c_valid = r_c_valid;
  assign bus.c_data  = r_c_data;
  assign bus.c_row   = r_c_row;
  assign bus.c_col   = r_c_col;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  // Lane i of A enters column 0 after i cycles; non-beat cycles inject zeros so bubbles keep alignment.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic signed [DW-1:0] w_inj;
    assign w_inj = w_beat ? bus.a_vec[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign w_a_edge[i] = w_inj;
    end else begin : g_delay
      logic signed [DW-1:0] r_sk [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned d = 0; d < i; d++) r_sk[d] <= '0;
        end else if (w_shift) begin
          r_sk[0] <= w_inj;
          for (int unsigned d = 1; d < i; d++) r_sk[d] <= r_sk[d-1];
        end
      end
      assign w_a_edge[i] = r_sk[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic signed [DW-1:0] w_inj;
    assign w_inj = w_beat ? bus.b_vec[j*DW +: DW] : '0;
    if (j == 0) begin : g_direct
      assign w_b_edge[j] = w_inj;
    end else begin : g_delay
      logic signed [DW-1:0] r_sk [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned d = 0; d < j; d++) r_sk[d] <= '0;
        end else if (w_shift) begin
          r_sk[0] <= w_inj;
          for (int unsigned d = 1; d < j; d++) r_sk[d] <= r_sk[d-1];
        end
      end
      assign w_b_edge[j] = r_sk[j-1];
    end
  end

  // A moves right and B moves down one PE per shift, so a beat meets itself at PE(i,j) after i+j cycles.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe
      logic signed [PW-1:0] w_prod;
      logic signed [AW-1:0] r_acc;

      if (j == 0) begin : g_a_in
        assign w_a_pe[i][j] = w_a_edge[i];
      end else begin : g_a_fwd
        logic signed [DW-1:0] r_a;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       r_a <= '0;
          else if (w_shift) r_a <= w_a_pe[i][j-1];
        end
        assign w_a_pe[i][j] = r_a;
      end

      if (i == 0) begin : g_b_in
        assign w_b_pe[i][j] = w_b_edge[j];
      end else begin : g_b_fwd
        logic signed [DW-1:0] r_b;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       r_b <= '0;
          else if (w_shift) r_b <= w_b_pe[i-1][j];
        end
        assign w_b_pe[i][j] = r_b;
      end

      assign w_prod = PW'(w_a_pe[i][j]) * PW'(w_b_pe[i][j]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_acc <= '0;
        else if (w_clear) r_acc <= '0;
        else if (w_shift) r_acc <= r_acc + AW'(w_prod);
      end
      assign w_acc[i][j] = r_acc;
    end
  end

  // Index of the result to present next: (0,0) before the first one, otherwise row-major successor.
  always_comb begin
    w_nrow = '0;
    w_ncol = '0;
    w_last = (r_c_row == RW'(ROWS - 1)) && (r_c_col == CW'(COLS - 1));
    if (r_c_valid) begin
      if (r_c_col == CW'(COLS - 1)) begin
        w_nrow = r_c_row + RW'(1);
        w_ncol = '0;
      end else begin
        w_nrow = r_c_row;
        w_ncol = r_c_col + CW'(1);
      end
    end
  end

  assign w_sel = w_acc[w_nrow][w_ncol];
  assign w_rnd = AW1'(w_sel) + RND_BIAS;
  assign w_shr = w_rnd >>> FRAC_WIDTH;

  always_comb begin
    w_res = w_shr[DW-1:0];
    if (w_shr > SAT_MAX)      w_res = SAT_MAX[DW-1:0];
    else if (w_shr < SAT_MIN) w_res = SAT_MIN[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_c_valid   <= 1'b0;
      r_c_data    <= '0;
      r_c_row     <= '0;
      r_c_col     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy      <= 1'b1;
            r_k_len     <= w_k_clamp;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_state     <= (w_k_clamp == '0) ? S_DRAIN : S_FEED;
          end
        end
        S_FEED: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
            if (r_beat_cnt == r_k_len - KW'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DCW'(DRAIN_LEN - 1)) begin
            r_drain_cnt <= '0;
            r_state     <= S_OUTPUT;
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
          end
        end
        S_OUTPUT: begin
          if (!r_c_valid) begin
            r_c_valid <= 1'b1;
            r_c_data  <= w_res;
            r_c_row   <= w_nrow;
            r_c_col   <= w_ncol;
          end else if (bus.c_ready) begin
            if (w_last) begin
              r_c_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_c_data <= w_res;
              r_c_row  <= w_nrow;
              r_c_col  <= w_ncol;
            end
          end
        end
      endcase
    end
  end
endmodule
